// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-port, variable-latency memory between the instruction
// fetch port (if_*) and the data-memory port (dm_*). Each access runs
// IDLE -> WAIT_IF/WAIT_DM -> RESP -> IDLE. A watchdog bounds the wait for
// mem_ready and aborts the access with an error flag.
//
// Handshake: a requester raises *_req with its command and holds both
// stable until it sees the one-cycle *_ack pulse. *_err qualifies *_ack.
// On the memory side mem_req and the command stay stable until mem_ready
// (sampled only while mem_req=1) or until the watchdog aborts.
//
// Ports:
//   clock, reset                  clock, synchronous active-high reset
//   if_req/if_addr                fetch request and address
//   if_rdata/if_ack/if_err        fetch response; if_stall = if_req & ~if_ack
//   dm_req/dm_we/dm_addr/dm_wdata data request and command
//   dm_rdata/dm_ack/dm_err        data response; dm_stall = dm_req & ~dm_ack
//   mem_req/mem_we/mem_addr/mem_wdata  memory command
//   mem_rdata/mem_ready           memory response
//   owner                         0 = fetch, 1 = data (last/current grant)
//   state_dbg                     current FSM state, for debug/checkers
//
// Build option: define ARB_FAIR_EN to alternate the grant when both ports
// are pending in IDLE; otherwise the data port always wins.

module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_err,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_err,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              owner,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_IF = 2'd1,
        WAIT_DM = 2'd2,
        RESP    = 2'd3
    } state_t;

    // The watchdog fires on the cycle the counter would reach MAX_WAIT, so
    // mem_req is high for at most MAX_WAIT cycles.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
    logic              mem_req_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n;
    logic [DATA_W-1:0] if_rdata_n, dm_rdata_n;
    logic              if_ack_n, dm_ack_n, if_err_n, dm_err_n;
    logic              owner_n;
    logic              grant_dm;

    always_comb begin
`ifdef ARB_FAIR_EN
        // Both pending: serve the port that did not own the last grant.
        grant_dm = dm_req & (~if_req | ~owner);
`else
        grant_dm = dm_req;
`endif
    end

    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_rdata_n  = if_rdata;
        dm_rdata_n  = dm_rdata;
        if_ack_n    = 1'b0;
        dm_ack_n    = 1'b0;
        if_err_n    = 1'b0;
        dm_err_n    = 1'b0;
        owner_n     = owner;

        case (state)
            IDLE: begin
                wait_cnt_n = '0;
                if (grant_dm) begin
                    state_n     = WAIT_DM;
                    mem_req_n   = 1'b1;
                    mem_we_n    = dm_we;
                    mem_addr_n  = dm_addr;
                    mem_wdata_n = dm_wdata;
                    owner_n     = 1'b1;
                end else if (if_req) begin
                    state_n    = WAIT_IF;
                    mem_req_n  = 1'b1;
                    mem_we_n   = 1'b0;
                    mem_addr_n = if_addr;
                    owner_n    = 1'b0;
                end
            end
            WAIT_IF, WAIT_DM: begin
                if (mem_ready) begin
                    state_n    = RESP;
                    mem_req_n  = 1'b0;
                    wait_cnt_n = '0;
                    if (state == WAIT_DM) begin
                        dm_ack_n = 1'b1;
                        // A completed write leaves the read data untouched.
                        if (!mem_we) begin
                            dm_rdata_n = mem_rdata;
                        end
                    end else begin
                        if_ack_n   = 1'b1;
                        if_rdata_n = mem_rdata;
                    end
                end else if (wait_cnt == LAST_WAIT) begin
                    state_n    = RESP;
                    mem_req_n  = 1'b0;
                    wait_cnt_n = '0;
                    if (state == WAIT_DM) begin
                        dm_ack_n   = 1'b1;
                        dm_err_n   = 1'b1;
                        dm_rdata_n = '0;
                    end else begin
                        if_ack_n   = 1'b1;
                        if_err_n   = 1'b1;
                        if_rdata_n = '0;
                    end
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            RESP: begin
                // Requests are not looked at here; the requester is still
                // retiring the acked access on this edge.
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
            if_err    <= 1'b0;
            dm_err    <= 1'b0;
            owner     <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_cnt_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if_rdata  <= if_rdata_n;
            dm_rdata  <= dm_rdata_n;
            if_ack    <= if_ack_n;
            dm_ack    <= dm_ack_n;
            if_err    <= if_err_n;
            dm_err    <= dm_err_n;
            owner     <= owner_n;
        end
    end

    assign if_stall  = if_req & ~if_ack;
    assign dm_stall  = dm_req & ~dm_ack;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by two
// concurrent random requesters, checked by a scoreboard and a cycle monitor
// against a behavioural model of the arbitration and memory timing.

module tb_mem_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack, if_err, if_stall;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack, dm_err, dm_stall;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;
    logic              owner;
    logic [1:0]        state_dbg;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_err(if_err), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner), .state_dbg(state_dbg)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    // Read data is a fixed function of the address; latency is per address
    // (directed overrides, otherwise derived from the address bits).
    int lat_map[logic [ADDR_W-1:0]];

    function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h2050_FFBF;
    endfunction

    function automatic int lat_of(input logic [ADDR_W-1:0] a);
        if (lat_map.exists(a)) return lat_map[a];
        return int'((a >> 8) % 18) + 1;
    endfunction

    logic force_ready = 1'b0;
    logic resp_prev_req = 1'b0;
    int   resp_cnt = 0;

    always @(negedge clock) begin
        mem_ready = 1'b0;
        mem_rdata = $urandom();
        if (mem_req === 1'b1) begin
            resp_cnt = resp_prev_req ? resp_cnt + 1 : 1;
            if (resp_cnt == lat_of(mem_addr)) begin
                mem_ready = 1'b1;
                mem_rdata = mem_data(mem_addr);
            end
        end else if ($urandom_range(0, 3) == 0) begin
            mem_ready = 1'b1;   // stray pulse while idle must be ignored
        end
        if (force_ready) mem_ready = 1'b1;
        resp_prev_req = (mem_req === 1'b1);
    end

    // ---------------- scoreboard + monitor ----------------
    logic [DATA_W:0] exp_if_q[$];   // {err, rdata}
    logic [DATA_W:0] exp_dm_q[$];

    logic              rst_prev = 1'b0, started = 1'b0;
    logic              if_prev, dm_prev, dm_we_prev, mem_req_prev;
    logic [ADDR_W-1:0] if_addr_prev, dm_addr_prev;
    logic [DATA_W-1:0] dm_wdata_prev;
    logic              own_model = 1'b0;
    logic              in_acc = 1'b0, acc_dm, acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    int                ack_cyc = 0;
    logic [DATA_W-1:0] hold_if = '0, hold_dm = '0;
    logic              exp_if_ack, exp_dm_ack, g;
    logic [DATA_W:0]   e;
    int                l;

    always @(negedge clock) begin
        if (rst_prev) begin
            chk("reset_state",
                {mem_req, mem_we, mem_addr, mem_wdata, if_ack, dm_ack, if_err, dm_err,
                 if_rdata, dm_rdata, owner}, '0);
            started   = 1'b1;
            own_model = 1'b0;
            in_acc    = 1'b0;
            hold_if   = '0;
            hold_dm   = '0;
        end else if (started) begin
            exp_if_ack = in_acc && !acc_dm && (cyc == ack_cyc);
            exp_dm_ack = in_acc && acc_dm && (cyc == ack_cyc);
            chk("if_ack_timing", if_ack, exp_if_ack);
            chk("dm_ack_timing", dm_ack, exp_dm_ack);
            chk("if_stall", if_stall, if_req & ~exp_if_ack);
            chk("dm_stall", dm_stall, dm_req & ~exp_dm_ack);

            if (mem_req && !mem_req_prev) begin
                chk("mem_req_overlap", in_acc, 1'b0);
                if (!if_prev && !dm_prev) begin
                    chk("mem_req_spurious", 1'b1, 1'b0);
                end else begin
`ifdef ARB_FAIR_EN
                    g = (if_prev && dm_prev) ? ~own_model : dm_prev;
`else
                    g = dm_prev;
`endif
                    acc_dm    = g;
                    acc_we    = g ? dm_we_prev : 1'b0;
                    acc_addr  = g ? dm_addr_prev : if_addr_prev;
                    acc_wdata = g ? dm_wdata_prev : '0;
                    chk("owner", owner, g);
                    l = lat_of(acc_addr);
                    ack_cyc   = cyc + ((l < MAX_WAIT) ? l : MAX_WAIT);
                    own_model = g;
                    in_acc    = 1'b1;
                end
            end

            if (in_acc && cyc < ack_cyc)
                chk("mem_cmd", {mem_req, mem_we, mem_addr, acc_dm ? mem_wdata : '0},
                    {1'b1, acc_we, acc_addr, acc_wdata});
            if (in_acc && cyc == ack_cyc) begin
                chk("mem_req_drop", mem_req, 1'b0);
                in_acc = 1'b0;
            end

            if (if_ack) begin
                if (exp_if_q.size() == 0) chk("if_ack_unexpected", 1'b1, 1'b0);
                else begin
                    e = exp_if_q.pop_front();
                    chk("if_resp", {if_err, if_rdata}, e);
                    hold_if = e[DATA_W-1:0];
                end
            end else chk("if_rdata_hold", {if_err, if_rdata}, {1'b0, hold_if});
            if (dm_ack) begin
                if (exp_dm_q.size() == 0) chk("dm_ack_unexpected", 1'b1, 1'b0);
                else begin
                    e = exp_dm_q.pop_front();
                    chk("dm_resp", {dm_err, dm_rdata}, e);
                    hold_dm = e[DATA_W-1:0];
                end
            end else chk("dm_rdata_hold", {dm_err, dm_rdata}, {1'b0, hold_dm});
        end
        rst_prev      = reset;
        if_prev       = if_req;
        dm_prev       = dm_req;
        if_addr_prev  = if_addr;
        dm_we_prev    = dm_we;
        dm_addr_prev  = dm_addr;
        dm_wdata_prev = dm_wdata;
        mem_req_prev  = (mem_req === 1'b1);
    end

    // ---------------- drivers ----------------
    logic [DATA_W-1:0] last_dm = '0;

    task automatic do_if(input logic [ADDR_W-1:0] a);
        bit got = 1'b0;
        exp_if_q.push_back(lat_of(a) > MAX_WAIT ? {1'b1, {DATA_W{1'b0}}} : {1'b0, mem_data(a)});
        if_addr = a;
        if_req  = 1'b1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clock);
            got = if_ack;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL if_ack_wait: no ack for addr %h within 1000 cycles", a);
        end
        @(posedge clock);
        #1;
        if_req  = 1'b0;
        if_addr = $urandom();
    endtask

    task automatic do_dm(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        bit got = 1'b0;
        if (lat_of(a) > MAX_WAIT) last_dm = '0;
        else if (!we) last_dm = mem_data(a);
        exp_dm_q.push_back({lat_of(a) > MAX_WAIT, last_dm});
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dm_req   = 1'b1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clock);
            got = dm_ack;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL dm_ack_wait: no ack for addr %h within 1000 cycles", a);
        end
        @(posedge clock);
        #1;
        dm_req   = 1'b0;
        dm_we    = $urandom_range(0, 1);
        dm_addr  = $urandom();
        dm_wdata = $urandom();
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [31:0] r = $urandom();
        return {1'b1, r[30:2], 2'b00};
    endfunction

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(posedge clock);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        lat_map[32'h40]  = 2;
        lat_map[32'h0]   = 1;
        lat_map[32'h4]   = 1;
        lat_map[32'h8]   = 1;
        lat_map[32'h100] = 5;
        lat_map[32'h104] = 3;
        lat_map[32'h200] = 100;
        lat_map[32'h300] = 100;
        lat_map[32'h44]  = 3;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // single fetch, 2-cycle memory
        do_if(32'h40);
        gap();
        // simultaneous fetch and data write, 1-cycle memory
        fork
            do_if(32'h8);
            do_dm(1'b1, 32'h8, 32'hDEAD_BEEF);
        join
        gap();
        // back-to-back fetches
        do_if(32'h0);
        do_if(32'h4);
        do_if(32'h8);
        // slow data read, then a write that must leave dm_rdata alone
        do_dm(1'b0, 32'h100, 32'h0);
        do_dm(1'b1, 32'h104, 32'h1234_5678);
        gap();
        // unresponsive memory: watchdog abort
        do_dm(1'b0, 32'h200, 32'h0);
        gap();

        // reset in the middle of a data wait, then a late mem_ready
        dm_we   = 1'b0;
        dm_addr = 32'h300;
        dm_req  = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        reset  = 1'b1;
        dm_req = 1'b0;
        @(posedge clock);
        #1;
        reset       = 1'b0;
        force_ready = 1'b1;
        last_dm     = '0;
        @(posedge clock);
        #1;
        force_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        do_if(32'h44);
        gap();

        // random concurrent traffic
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    do_if(rand_addr());
                    gap();
                end
            end
            begin
                for (int j = 0; j < 60; j++) begin
                    do_dm(1'($urandom_range(0, 1)), rand_addr(), $urandom());
                    gap();
                end
            end
        join

        repeat (5) @(posedge clock);
        chk("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
        chk("dm_queue_drained", 32'(exp_dm_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

endmodule
